// File: rtl/jamma_input_ctrl_pkg.sv
// Shared definitions for the JAMMA input controller: scan FSM encoding,
// idle levels and default parameter values.
package jamma_input_ctrl_pkg;

    typedef enum logic [1:0] {
        A_SETTLE = 2'd0,
        A_SAMPLE = 2'd1,
        B_SETTLE = 2'd2,
        B_SAMPLE = 2'd3
    } scan_state_e;

    localparam logic [7:0]  JOY_IDLE          = 8'hFF;
    localparam logic [1:0]  COIN_IDLE         = 2'b11;
    localparam int unsigned SETTLE_CYCLES_DEF = 4;
    localparam int unsigned DB_W_DEF          = 4;

    // Player B owns the bus in both of its states.
    function automatic logic is_b_side(input scan_state_e st);
        return (st == B_SETTLE) || (st == B_SAMPLE);
    endfunction

endpackage

// File: rtl/jamma_debounce_bit.sv
// Single-bit debouncer with evaluation enable; idle level is 1 (active-low inputs).
// JAMMA_DEBOUNCE_EN builds the counter; otherwise the stable flop takes raw on each enable.
module jamma_debounce_bit
    import jamma_input_ctrl_pkg::*;
`ifdef JAMMA_DEBOUNCE_EN
#(
    parameter int unsigned DB_W = DB_W_DEF
)
`endif
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic raw_i,
    output logic stable_o
);

    logic stable_q;
    logic stable_d;

`ifdef JAMMA_DEBOUNCE_EN
    // Last count before the threshold 2^DB_W-1 is reached.
    localparam logic [DB_W-1:0] CNT_LAST = DB_W'((2 ** DB_W) - 2);

    logic [DB_W-1:0] cnt_q;
    logic [DB_W-1:0] cnt_d;

    // Count consecutive disagreeing evaluations; any agreeing one restarts from zero.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (en_i) begin
            if (raw_i == stable_q) begin
                cnt_d = {DB_W{1'b0}};
            end else if (cnt_q == CNT_LAST) begin
                stable_d = raw_i;
                cnt_d    = {DB_W{1'b0}};
            end else begin
                cnt_d = cnt_q + DB_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Disagreement counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= {DB_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // Without debouncing the stable value simply follows raw on each evaluation.
    always_comb begin
        if (en_i) begin
            stable_d = raw_i;
        end else begin
            stable_d = stable_q;
        end
    end
`endif

    // Stable value flop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stable_q <= 1'b1;
        end else begin
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/jamma_input_ctrl.sv
// JAMMA two-player input scanner: multiplexes the player bank via O_JSELECT,
// merges the keyboard into player A and conditions coins. Debounce via JAMMA_DEBOUNCE_EN.
module jamma_input_ctrl
    import jamma_input_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int unsigned DB_W          = DB_W_DEF
)(
    input  logic       I_CLK,
    input  logic       I_RESET_N,
    input  logic [7:0] I_JJOY,
    input  logic [1:0] I_JCOIN,
    input  logic [5:0] I_KEY_JOY,
    output logic       O_JSELECT,
    output logic [7:0] O_JOY_A,
    output logic [7:0] O_JOY_B,
    output logic [1:0] O_COIN,
    output logic       O_SCAN_TICK
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("jamma_input_ctrl: SETTLE_CYCLES must be 1..15");
    end
    if (DB_W < 1 || DB_W > 8) begin : g_bad_db_w
        $error("jamma_input_ctrl: DB_W must be 1..8");
    end

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    scan_state_e state_q, state_d;
    logic [3:0]  settle_cnt_q, settle_cnt_d;
    logic        jsel_q, tick_q;
    logic [1:0]  coin_meta_q, coin_sync_q;
    logic        sample_a_s, sample_b_s;
    logic [7:0]  raw_a_s, raw_b_s;

    // Scan sequencing; the settle counter restarts on every state change.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = 4'd0;
        case (state_q)
            A_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = A_SAMPLE;
                end else begin
                    settle_cnt_d = settle_cnt_q + 4'd1;
                end
            end
            A_SAMPLE: state_d = B_SETTLE;
            B_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = B_SAMPLE;
                end else begin
                    settle_cnt_d = settle_cnt_q + 4'd1;
                end
            end
            B_SAMPLE: state_d = A_SETTLE;
            default:  state_d = A_SETTLE;
        endcase
    end

    // FSM, bank select and scan tick registers.
    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            state_q      <= A_SETTLE;
            settle_cnt_q <= 4'd0;
            jsel_q       <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            jsel_q       <= is_b_side(state_d);
            tick_q       <= (state_q == B_SAMPLE);
        end
    end

    // Two-flop synchroniser for the asynchronous coin switches.
    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            coin_meta_q <= COIN_IDLE;
            coin_sync_q <= COIN_IDLE;
        end else begin
            coin_meta_q <= I_JCOIN;
            coin_sync_q <= coin_meta_q;
        end
    end

    assign sample_a_s = (state_q == A_SAMPLE);
    assign sample_b_s = (state_q == B_SAMPLE);
    // Active-low, so AND means either source pressed reads as pressed.
    assign raw_a_s    = I_JJOY & {2'b11, I_KEY_JOY};
    assign raw_b_s    = I_JJOY;

    for (genvar i = 0; i < 8; i++) begin : g_joy
        jamma_debounce_bit
`ifdef JAMMA_DEBOUNCE_EN
            #(.DB_W(DB_W))
`endif
            u_deb_a (.clk_i(I_CLK), .rst_ni(I_RESET_N), .en_i(sample_a_s), .raw_i(raw_a_s[i]), .stable_o(O_JOY_A[i]));
        jamma_debounce_bit
`ifdef JAMMA_DEBOUNCE_EN
            #(.DB_W(DB_W))
`endif
            u_deb_b (.clk_i(I_CLK), .rst_ni(I_RESET_N), .en_i(sample_b_s), .raw_i(raw_b_s[i]), .stable_o(O_JOY_B[i]));
    end

    for (genvar i = 0; i < 2; i++) begin : g_coin
        jamma_debounce_bit
`ifdef JAMMA_DEBOUNCE_EN
            #(.DB_W(DB_W))
`endif
            u_deb_coin (.clk_i(I_CLK), .rst_ni(I_RESET_N), .en_i(1'b1), .raw_i(coin_sync_q[i]), .stable_o(O_COIN[i]));
    end

    assign O_JSELECT   = jsel_q;
    assign O_SCAN_TICK = tick_q;

endmodule

// File: tb/tb_jamma_input_ctrl.sv
// Self-checking bench for jamma_input_ctrl: scan-schedule/window model plus
// literal expectations for the directed scenarios.
module tb_jamma_input_ctrl;
    import jamma_input_ctrl_pkg::*;

    localparam int S   = 4;
    localparam int DBW = 4;
    localparam int P   = 2 * (S + 1);
`ifdef JAMMA_DEBOUNCE_EN
    localparam int          TH             = (1 << DBW) - 1;
    localparam int          TH_LIT         = 15;
    localparam int          COIN_EDGES_LIT = 17;
    localparam logic [7:0]  BOUNCE2_LIT    = 8'hFF;
`else
    localparam int          TH             = 1;
    localparam int          TH_LIT         = 1;
    localparam int          COIN_EDGES_LIT = 3;
    localparam logic [7:0]  BOUNCE2_LIT    = 8'hFE;
`endif

    logic       I_CLK = 1'b0;
    logic       I_RESET_N = 1'b1;
    logic [7:0] I_JJOY = 8'hFF;
    logic [1:0] I_JCOIN = 2'b11;
    logic [5:0] I_KEY_JOY = 6'h3F;
    logic       O_JSELECT;
    logic [7:0] O_JOY_A, O_JOY_B;
    logic [1:0] O_COIN;
    logic       O_SCAN_TICK;

    jamma_input_ctrl #(.SETTLE_CYCLES(S), .DB_W(DBW)) dut (
        .I_CLK(I_CLK), .I_RESET_N(I_RESET_N), .I_JJOY(I_JJOY), .I_JCOIN(I_JCOIN),
        .I_KEY_JOY(I_KEY_JOY), .O_JSELECT(O_JSELECT), .O_JOY_A(O_JOY_A),
        .O_JOY_B(O_JOY_B), .O_COIN(O_COIN), .O_SCAN_TICK(O_SCAN_TICK)
    );

    always #5 I_CLK = ~I_CLK;

    int errors = 0;
    int checks = 0;

    // Model state: cycle number since reset release and sample histories.
    int         cyc = 0;
    bit         in_rst = 1'b1;
    logic [7:0] m_a = 8'hFF, m_b = 8'hFF, m_c = 8'hFF;
    logic       m_tick = 1'b0;
    logic [7:0] hist_a[$], hist_b[$], hist_c[$];
    logic [1:0] coin_pipe[$];
    int         a_samples = 0, b_samples = 0;
    int         first_tick = 0;
    logic [19:0] jpat = 20'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A bit flips once the last TH evaluations all disagree with it.
    function automatic logic [7:0] settle_vec(input logic [7:0] st, input logic [7:0] h[$]);
        logic [7:0] r = st;
        if (h.size() >= TH) begin
            for (int b = 0; b < 8; b++) begin
                bit all_diff = 1'b1;
                for (int k = h.size() - TH; k < h.size(); k++)
                    if (h[k][b] == st[b]) all_diff = 1'b0;
                if (all_diff) r[b] = ~st[b];
            end
        end
        return r;
    endfunction

    task automatic model_edge(input logic [7:0] jj, input logic [5:0] key, input logic [1:0] coin);
        int ph;
        logic [1:0] ev;
        if (in_rst) return;
        ph = (cyc - 1) % P;
        m_tick = (ph == 2 * S + 1);
        if (ph == S) begin
            hist_a.push_back(jj & {2'b11, key});
            if (hist_a.size() > TH) void'(hist_a.pop_front());
            m_a = settle_vec(m_a, hist_a);
            a_samples++;
        end
        if (ph == 2 * S + 1) begin
            hist_b.push_back(jj);
            if (hist_b.size() > TH) void'(hist_b.pop_front());
            m_b = settle_vec(m_b, hist_b);
            b_samples++;
        end
        coin_pipe.push_back(coin);
        ev = coin_pipe.pop_front();
        hist_c.push_back({6'h3F, ev});
        if (hist_c.size() > TH) void'(hist_c.pop_front());
        m_c = settle_vec(m_c, hist_c);
        cyc++;
    endtask

    task automatic check_all();
        logic exp_j;
        exp_j = in_rst ? 1'b0 : (((cyc - 1) % P) >= S + 1);
        chk("jselect", O_JSELECT, exp_j);
        chk("joy_a", O_JOY_A, m_a);
        chk("joy_b", O_JOY_B, m_b);
        chk("coin", O_COIN, m_c[1:0]);
        chk("scan_tick", O_SCAN_TICK, m_tick);
        if (!in_rst) begin
            if (cyc >= 1 && cyc <= 20) jpat[cyc - 1] = O_JSELECT;
            if (O_SCAN_TICK && first_tick == 0) first_tick = cyc;
        end
    endtask

    task automatic step();
        logic [7:0] jj = I_JJOY;
        logic [5:0] key = I_KEY_JOY;
        logic [1:0] coin = I_JCOIN;
        @(posedge I_CLK);
        model_edge(jj, key, coin);
        @(negedge I_CLK);
        check_all();
    endtask

    task automatic step_scan(input logic [7:0] a, input logic [7:0] b);
        I_JJOY = (((cyc - 1) % P) <= S) ? a : b;
        step();
    endtask

    task automatic a_sample(input logic [7:0] a, input logic [7:0] b);
        int base = a_samples;
        for (int k = 0; k < 2 * P && a_samples == base; k++) step_scan(a, b);
    endtask

    // Called at a negedge: asserts reset, checks immediate effect, releases.
    task automatic do_reset();
        I_RESET_N = 1'b0;
        #1;
        chk("rst_jselect", O_JSELECT, 1'b0);
        chk("rst_joy_a", O_JOY_A, 8'hFF);
        chk("rst_joy_b", O_JOY_B, 8'hFF);
        chk("rst_coin", O_COIN, 2'b11);
        chk("rst_tick", O_SCAN_TICK, 1'b0);
        in_rst = 1'b1;
        m_a = 8'hFF; m_b = 8'hFF; m_c = 8'hFF; m_tick = 1'b0;
        hist_a.delete(); hist_b.delete(); hist_c.delete();
        coin_pipe.delete();
        coin_pipe.push_back(2'b11);
        coin_pipe.push_back(2'b11);
        @(negedge I_CLK);
        step();
        step();
        I_RESET_N = 1'b1;
        in_rst = 1'b0;
        cyc = 1;
        first_tick = 0;
        jpat = 20'd0;
        check_all();
    endtask

    initial begin
        int n_hit;
        @(negedge I_CLK);
        do_reset();

        // Select pattern and first tick after reset release.
        repeat (24) step_scan(8'hFF, 8'hFF);
        chk("jsel_pattern", jpat, 20'hF83E0);
        chk("first_tick_cycle", first_tick, 11);

        // Player A bit 0 held low only in A windows.
        n_hit = 0;
        for (int k = 1; k <= 20; k++) begin
            a_sample(8'hFE, 8'hFF);
            if (n_hit == 0 && O_JOY_A[0] == 1'b0) n_hit = k;
        end
        chk("deb_a_samples", n_hit, TH_LIT);
        chk("deb_a_value", O_JOY_A, 8'hFE);
        chk("deb_b_idle", O_JOY_B, 8'hFF);
        repeat (16) a_sample(8'hFF, 8'hFF);
        chk("deb_a_release", O_JOY_A, 8'hFF);

        // Bounce: 14 low then 1 high, then the count restarts.
        repeat (14) a_sample(8'hFE, 8'hFF);
        a_sample(8'hFF, 8'hFF);
        chk("bounce_hold", O_JOY_A, 8'hFF);
        repeat (14) a_sample(8'hFE, 8'hFF);
        chk("bounce_restart", O_JOY_A, BOUNCE2_LIT);
        a_sample(8'hFE, 8'hFF);
        chk("bounce_settle", O_JOY_A, 8'hFE);
        repeat (16) a_sample(8'hFF, 8'hFF);

        // Keyboard merged into player A only.
        I_KEY_JOY = 6'b111101;
        repeat (16) a_sample(8'hFF, 8'hFF);
        chk("key_merge_a", O_JOY_A, 8'hFD);
        chk("key_not_b", O_JOY_B, 8'hFF);

        // Same-sample AND merge, and a distinct player B pattern.
        I_KEY_JOY = 6'b111110;
        repeat (16) a_sample(8'hFD, 8'h7F);
        chk("and_merge_a", O_JOY_A, 8'hFC);
        chk("joy_b_start", O_JOY_B, 8'h7F);

        // Reset during B_SETTLE.
        for (int k = 0; k < P && ((cyc - 1) % P) != S + 2; k++) step_scan(8'hFD, 8'h7F);
        chk("in_b_settle", O_JSELECT, 1'b1);
        I_KEY_JOY = 6'h3F;
        I_JJOY = 8'hFF;
        do_reset();
        repeat (24) step_scan(8'hFF, 8'hFF);
        chk("jsel_pattern_rst", jpat, 20'hF83E0);
        chk("first_tick_rst", first_tick, 11);

        // Coin 1 low for 20 cycles, then high.
        I_JCOIN = 2'b01;
        n_hit = 0;
        for (int k = 1; k <= 20; k++) begin
            step_scan(8'hFF, 8'hFF);
            if (n_hit == 0 && O_COIN[1] == 1'b0) n_hit = k;
        end
        chk("coin_fall_edges", n_hit, COIN_EDGES_LIT);
        I_JCOIN = 2'b11;
        n_hit = 0;
        for (int k = 1; k <= 20; k++) begin
            step_scan(8'hFF, 8'hFF);
            if (n_hit == 0 && O_COIN[1] == 1'b1) n_hit = k;
        end
        chk("coin_rise_edges", n_hit, COIN_EDGES_LIT);
        chk("coin0_idle", O_COIN[0], 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jamma_input_ctrl.md
JAMMA_INPUT_CTRL -- requirements
Module: jamma_input_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: idle cycles after each JSELECT change before JJOY is sampled; legal range 1..15.
REQ-002 Parameter DB_W, default 4: debounce counter width; an input must disagree with its stable value for 2^DB_W-1 consecutive evaluations before the stable value changes.
REQ-003 I_CLK  in  1: single clock (pclk domain); the only clock; all outputs registered on its rising edge.
REQ-004 I_RESET_N  in  1: asynchronous, active-low reset.
REQ-005 I_JJOY  in  8: multiplexed JAMMA player bank, active-low; bits 5:0 joystick/buttons, bit 7 start, bit 6 spare.
REQ-006 I_JCOIN  in  2: coin inputs, active-low, asynchronous.
REQ-007 I_KEY_JOY  in  6: keyboard joystick, active-low; merged into player A.
REQ-008 O_JSELECT  out  1: bank select to the JAMMA adapter; 0 selects player A, 1 selects player B.
REQ-009 O_JOY_A  out  8: player A, active-low.
REQ-010 O_JOY_B  out  8: player B, active-low.
REQ-011 O_COIN  out  2: conditioned coins, active-low.
REQ-012 O_SCAN_TICK  out  1: one-cycle pulse, high in the cycle after O_JOY_B is updated.

Function
REQ-013 The FSM SHALL cycle through four states: A_SETTLE -> A_SAMPLE -> B_SETTLE -> B_SAMPLE -> A_SETTLE.
REQ-014 O_JSELECT SHALL be 0 in A_SETTLE and A_SAMPLE, and 1 in B_SETTLE and B_SAMPLE.
REQ-015 Each SETTLE state SHALL last exactly SETTLE_CYCLES cycles, counted by a 4-bit counter cleared on state entry; each SAMPLE state SHALL last exactly 1 cycle.
REQ-016 The scan period SHALL be 2*(SETTLE_CYCLES+1) cycles, which is 10 cycles at the default.
REQ-017 In A_SAMPLE, raw_a SHALL capture I_JJOY & {2'b11, I_KEY_JOY}; in B_SAMPLE, raw_b SHALL capture I_JJOY.
REQ-018 Each player bit SHALL be debounced once per SAMPLE event of its own player, never in SETTLE states.
REQ-019 Debounce rule per bit: if raw equals stable, the counter is cleared; otherwise the counter increments; when it reaches 2^DB_W-1, stable takes raw and the counter is cleared.
REQ-020 A counter SHALL NOT wrap; a single agreeing sample SHALL restart the count from 0.
REQ-021 O_JOY_A and O_JOY_B SHALL equal the stable registers and SHALL change only in the cycle following the corresponding SAMPLE state.
REQ-022 I_JCOIN SHALL pass through a 2-flop synchroniser and then be debounced by the REQ-019 rule, evaluated every clock cycle.
REQ-023 O_SCAN_TICK SHALL assert for one cycle after every B_SAMPLE, whether or not any data changed.
REQ-024 Keyboard and JAMMA presses in the same sample SHALL merge with AND (either input low gives low).

Reset
REQ-025 Asserting I_RESET_N low SHALL immediately force: FSM to A_SETTLE, counters to 0, O_JSELECT=0, O_JOY_A=O_JOY_B=8'hFF, O_COIN=2'b11, O_SCAN_TICK=0, raw and sync registers to all-ones.
REQ-026 Reset asserted mid-scan SHALL abandon the scan in progress; after release, the first sample SHALL occur SETTLE_CYCLES cycles later, in A_SAMPLE.

Configuration
REQ-027 With JAMMA_DEBOUNCE_EN defined, the REQ-019/REQ-022 debounce logic SHALL be built.
REQ-028 Without JAMMA_DEBOUNCE_EN, stable SHALL take raw at each SAMPLE (coins: the synchroniser output), no counters SHALL be instantiated, and latency SHALL be one cycle after sampling.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (2-bit), JOY_IDLE=8'hFF, COIN_IDLE=2'b11, and the default values of SETTLE_CYCLES and DB_W.
REQ-030 One sub-module, jamma_debounce_bit, SHALL implement a per-bit counter and stable flop with an enable input, instantiated 18 times (8+8+2).

Verification
REQ-031 Reset release with defaults -> O_JSELECT low for 5 cycles, high for 5, repeating; first O_SCAN_TICK at cycle 11.
REQ-032 I_JJOY=8'hFE held during player A windows only, debounce enabled -> O_JOY_A[0]=0 after the 15th A sample; O_JOY_B stays 8'hFF.
REQ-033 Bounce: bit 0 toggles low for 14 A samples, then high for 1 -> O_JOY_A stays 8'hFF; the counter restarts.
REQ-034 I_KEY_JOY=6'b111101 with I_JJOY=8'hFF -> O_JOY_A=8'hFD after debounce; O_JOY_B=8'hFF.
REQ-035 I_JCOIN[1] low for 20 cycles -> O_COIN[1]=0 at cycle 2+15; returns to 1 after 15 cycles high.
REQ-036 I_RESET_N pulsed low during B_SETTLE -> all outputs at their reset values in the same cycle; the scan restarts at A_SETTLE.
